// File: rtl/pong_engine_if.sv
// Frame-level I/O of the Pong engine: vsync and keys in, sprite coordinates,
// scores and game status out to the renderers.
interface pong_engine_if;
  logic       vsync;
  logic       up0_n, down0_n, up1_n, down1_n, serve_n;
  logic [9:0] pad0_y, pad1_y;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score0, score1;
  logic [1:0] state;
  logic       collision;
  logic       winner;

  modport master (
    output vsync, up0_n, down0_n, up1_n, down1_n, serve_n,
    input  pad0_y, pad1_y, ball_x, ball_y, score0, score1, state, collision, winner
  );

  modport slave (
    input  vsync, up0_n, down0_n, up1_n, down1_n, serve_n,
    output pad0_y, pad1_y, ball_x, ball_y, score0, score1, state, collision, winner
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game core: paddles, ball, scoring and serve/point/over sequencing,
// all advanced once per frame on the vsync falling edge using coordinate tests.
module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BORDER       = 8,
  parameter int PAD_X0       = 16,
  parameter int PAD_X1       = 616,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int BALL_S       = 8,
  parameter int PAD_SPEED    = 4,
  parameter int BALL_DX      = 2,
  parameter int BALL_DY      = 2,
  parameter int WIN_SCORE    = 7,
  parameter int POINT_FRAMES = 60
) (
  input  logic         clk,
  input  logic         reset,
  pong_engine_if.slave io
);
  localparam int PAD_MAX = V_RES - BORDER - PAD_H;
  localparam int PAD_C   = (V_RES - PAD_H) / 2;
  localparam int BX_C    = (H_RES - BALL_S) / 2;
  localparam int BY_C    = (V_RES - BALL_S) / 2;
  localparam int PCW     = $clog2(POINT_FRAMES + 1);
  localparam logic [3:0] WS = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;
  state_t st, st_nxt;

  logic [4:0]     key_m, key_s;
  logic           vs_q, tick;
  logic           up0, dn0, up1, dn1, serve;
  logic [9:0]     pad0_y, pad1_y, ball_x, ball_y;
  logic [3:0]     score0, score1;
  logic           dir_x, dir_y, serve_dir;  // dir_x 1 = right, dir_y 1 = down
  logic           collision, winner;
  logic [PCW-1:0] pt_cnt;

  int   nx, ny, p0, p1;
  logic hit0, hit1, miss0, miss1, wall_top, wall_bot, pt_done, win_any;

  always_ff @(posedge clk) begin
    vs_q <= io.vsync;
    if (reset) begin
      key_m <= '1;
      key_s <= '1;
    end else begin
      key_m <= {io.serve_n, io.down1_n, io.up1_n, io.down0_n, io.up0_n};
      key_s <= key_m;
    end
  end

  assign {serve, dn1, up1, dn0, up0} = ~key_s;
  assign tick = vs_q & ~io.vsync;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    int v;
    v = int'(y);
    if (up && !dn)      v = (v - PAD_SPEED < BORDER)  ? BORDER  : v - PAD_SPEED;
    else if (dn && !up) v = (v + PAD_SPEED > PAD_MAX) ? PAD_MAX : v + PAD_SPEED;
    return 10'(v);
  endfunction

  // Geometry is evaluated in signed int so a ball near x=0 cannot wrap.
  always_comb begin
    p0       = int'(pad0_y);
    p1       = int'(pad1_y);
    nx       = dir_x ? int'(ball_x) + BALL_DX : int'(ball_x) - BALL_DX;
    ny       = dir_y ? int'(ball_y) + BALL_DY : int'(ball_y) - BALL_DY;
    hit0     = !dir_x && (nx <= PAD_X0 + PAD_W) && (nx + BALL_S > PAD_X0)
               && (ny + BALL_S > p0) && (ny < p0 + PAD_H);
    hit1     =  dir_x && (nx + BALL_S >= PAD_X1) && (nx < PAD_X1 + PAD_W)
               && (ny + BALL_S > p1) && (ny < p1 + PAD_H);
    miss0    = !dir_x && (int'(ball_x) < BALL_DX) && !hit0;
    miss1    =  dir_x && (nx + BALL_S >= H_RES) && !hit1;
    wall_top = (ny <= BORDER);
    wall_bot = (ny + BALL_S >= V_RES - BORDER);
    pt_done  = (pt_cnt == PCW'(POINT_FRAMES - 1));
    win_any  = (score0 == WS) || (score1 == WS);
  end

  always_comb begin
    st_nxt = st;
    if (tick) begin
      case (st)
        SERVE: if (serve) st_nxt = PLAY;
        PLAY:  if (miss0 || miss1) st_nxt = POINT;
        POINT: if (pt_done) st_nxt = win_any ? OVER : SERVE;
        OVER:  if (serve) st_nxt = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st <= SERVE;
    else       st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pad0_y    <= 10'(PAD_C);
      pad1_y    <= 10'(PAD_C);
      ball_x    <= 10'(BX_C);
      ball_y    <= 10'(BY_C);
      score0    <= '0;
      score1    <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_dir <= 1'b1;
      collision <= 1'b0;
      winner    <= 1'b0;
      pt_cnt    <= '0;
    end else begin
      collision <= 1'b0;
      if (tick) begin
        if (st == SERVE || st == PLAY) begin
          pad0_y <= pad_step(pad0_y, up0, dn0);
          pad1_y <= pad_step(pad1_y, up1, dn1);
        end
        case (st)
          SERVE: if (serve) begin
            dir_x <= serve_dir;
            dir_y <= 1'b1;
          end
          PLAY: if (miss0 || miss1) begin
            if (miss0) begin
              if (score1 != WS) score1 <= score1 + 4'd1;
              serve_dir <= 1'b0;
            end else begin
              if (score0 != WS) score0 <= score0 + 4'd1;
              serve_dir <= 1'b1;
            end
            ball_x <= 10'(BX_C);
            ball_y <= 10'(BY_C);
            pt_cnt <= '0;
          end else begin
            // A paddle hit snaps the ball flush to the paddle face.
            ball_x <= hit0 ? 10'(PAD_X0 + PAD_W) : hit1 ? 10'(PAD_X1 - BALL_S) : 10'(nx);
            if (hit0 || hit1) begin
              dir_x     <= hit0;
              collision <= 1'b1;
            end
            if (wall_top) begin
              ball_y <= 10'(BORDER);
              dir_y  <= 1'b1;
            end else if (wall_bot) begin
              ball_y <= 10'(V_RES - BORDER - BALL_S);
              dir_y  <= 1'b0;
            end else begin
              ball_y <= 10'(ny);
            end
          end
          POINT: begin
            pt_cnt <= pt_cnt + PCW'(1);
            if (pt_done && win_any) winner <= (score1 == WS);
          end
          OVER: if (serve) begin
            score0    <= '0;
            score1    <= '0;
            pad0_y    <= 10'(PAD_C);
            pad1_y    <= 10'(PAD_C);
            serve_dir <= 1'b1;
          end
        endcase
      end
    end
  end

  assign io.pad0_y    = pad0_y;
  assign io.pad1_y    = pad1_y;
  assign io.ball_x    = ball_x;
  assign io.ball_y    = ball_y;
  assign io.score0    = score0;
  assign io.score1    = score1;
  assign io.state     = st;
  assign io.collision = collision;
  assign io.winner    = winner;
endmodule

// File: tb/tb_pong_engine.sv
// Directed frame-by-frame bench for pong_engine: each stimulus frame queues its
// expected outputs and an independent monitor checks them after every tick.
module tb_pong_engine;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pong_engine_if io ();
  pong_engine dut (.clk(clk), .reset(reset), .io(io));

  typedef struct {
    string nm;
    int p0, p1, bx, by, s0, s1, st, col, win;
    logic [6:0] m;  // field enables: p0,p1,ball,scores,state,col,win
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic vs_last = 1'b1, rs_last = 1'b0, col_next = 1'b0;
  logic fire, tickd;

  function automatic exp_t mk(string nm, int p0, int p1, int bx, int by, int s0, int s1,
                              int st, int col, int win, logic [6:0] m = 7'h7f);
    exp_t e;
    e.nm = nm; e.p0 = p0; e.p1 = p1; e.bx = bx; e.by = by; e.s0 = s0; e.s1 = s1;
    e.st = st; e.col = col; e.win = win; e.m = m;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, want %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: fires on the tick edge and on the first edge after reset is released.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      tickd   = vs_last && !io.vsync;
      fire    = tickd || (rs_last && !reset);
      vs_last = io.vsync;
      rs_last = reset;
      #1;
      if (col_next) chk("pulse", "collision_after", int'(io.collision), 0);
      col_next = tickd;
      if (fire) begin
        if (sb.size() == 0) begin
          chk("scoreboard", "underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.m[0]) chk(e.nm, "pad0_y", int'(io.pad0_y), e.p0);
          if (e.m[1]) chk(e.nm, "pad1_y", int'(io.pad1_y), e.p1);
          if (e.m[2]) begin
            chk(e.nm, "ball_x", int'(io.ball_x), e.bx);
            chk(e.nm, "ball_y", int'(io.ball_y), e.by);
          end
          if (e.m[3]) begin
            chk(e.nm, "score0", int'(io.score0), e.s0);
            chk(e.nm, "score1", int'(io.score1), e.s1);
          end
          if (e.m[4]) chk(e.nm, "state", int'(io.state), e.st);
          if (e.m[5]) chk(e.nm, "collision", int'(io.collision), e.col);
          if (e.m[6]) chk(e.nm, "winner", int'(io.winner), e.win);
        end
      end
    end
  end

  task automatic frame(input exp_t e);
    sb.push_back(e);
    repeat (4) @(negedge clk);
    io.vsync = 1'b0;
    @(negedge clk);
    io.vsync = 1'b1;
  endtask

  task automatic point_hold(input string nm, input int p0, input int p1, input int s0,
                            input int s1, input int last_st, input int last_win);
    for (int p = 1; p <= 60; p++)
      frame(mk(nm, p0, p1, 316, 236, s0, s1, (p == 60) ? last_st : 2, 0,
               (p == 60) ? last_win : 0));
  endtask

  function automatic int y_down_first(int m);
    return (m <= 114) ? 236 + 2 * m : 464 - 2 * (m - 114);
  endfunction

  initial begin
    io.vsync = 1'b1;
    io.up0_n = 1'b1; io.down0_n = 1'b1; io.up1_n = 1'b1; io.down1_n = 1'b1;
    io.serve_n = 1'b1;

    sb.push_back(mk("reset0", 208, 208, 316, 236, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // paddle 0 up to the top clamp, then both keys
    io.up0_n = 1'b0;
    for (int i = 1; i <= 60; i++)
      frame(mk("pad_up", (208 - 4 * i < 8) ? 8 : 208 - 4 * i, 208, 316, 236, 0, 0, 0, 0, 0));
    io.down0_n = 1'b0;
    repeat (2) frame(mk("both_keys", 8, 208, 316, 236, 0, 0, 0, 0, 0));

    // both paddles down to the bottom clamp
    io.up0_n = 1'b1; io.down1_n = 1'b0;
    for (int i = 1; i <= 100; i++)
      frame(mk("pad_down", (8 + 4 * i > 408) ? 408 : 8 + 4 * i,
               (208 + 4 * i > 408) ? 408 : 208 + 4 * i, 316, 236, 0, 0, 0, 0, 0));
    io.down0_n = 1'b1; io.down1_n = 1'b1;

    // rally 1: serve right, bottom wall, raise pad1 into the path, hit
    io.serve_n = 1'b0;
    frame(mk("serve1", 408, 408, 316, 236, 0, 0, 1, 0, 0));
    io.serve_n = 1'b1;
    for (int m = 1; m <= 146; m++) begin
      if (m == 116) io.up1_n = 1'b0;
      if (m == 126) io.up1_n = 1'b1;
      frame(mk((m == 146) ? "hit_right" : (m == 114) ? "wall_bot" : "rally1",
               408, (m < 116) ? 408 : (m < 126) ? 408 - 4 * (m - 115) : 368,
               (m == 146) ? 608 : 316 + 2 * m, y_down_first(m), 0, 0, 1,
               (m == 146) ? 1 : 0, 0));
    end
    // return leftwards, top wall, miss pad0
    for (int n = 1; n <= 305; n++) begin
      if (n == 305)
        frame(mk("miss_left", 408, 368, 316, 236, 0, 1, 2, 0, 0));
      else
        frame(mk((n == 196) ? "wall_top" : "return", 408, 368, 608 - 2 * n,
                 (n <= 196) ? 400 - 2 * n : 8 + 2 * (n - 196), 0, 0, 1, 0, 0));
    end
    point_hold("point1", 408, 368, 0, 1, 0, 0);

    // player 1 keeps scoring on leftward serves until the game ends
    for (int k = 2; k <= 7; k++) begin
      io.serve_n = 1'b0;
      frame(mk("serve_left", 408, 368, 316, 236, 0, k - 1, 1, 0, 0));
      io.serve_n = 1'b1;
      for (int m = 1; m <= 159; m++) begin
        if (m == 159)
          frame(mk("miss_left_k", 408, 368, 316, 236, 0, k, 2, 0, 0));
        else
          frame(mk("rally_left", 408, 368, 316 - 2 * m, y_down_first(m), 0, k - 1, 1, 0, 0));
      end
      point_hold("point_k", 408, 368, 0, k, (k == 7) ? 3 : 0, (k == 7) ? 1 : 0);
    end

    // game over: keys ignored, then restart
    io.up0_n = 1'b0; io.down1_n = 1'b0;
    repeat (2) frame(mk("over_frozen", 408, 368, 316, 236, 0, 7, 3, 0, 1));
    io.up0_n = 1'b1; io.down1_n = 1'b1; io.serve_n = 1'b0;
    frame(mk("restart", 208, 208, 316, 236, 0, 0, 0, 0, 0, 7'h3f));
    io.serve_n = 1'b1;

    // serve right past pad1 for a player-0 point
    io.serve_n = 1'b0;
    frame(mk("serve_r2", 208, 208, 316, 236, 0, 0, 1, 0, 0, 7'h3f));
    io.serve_n = 1'b1;
    for (int m = 1; m <= 158; m++) begin
      if (m == 158)
        frame(mk("miss_right", 208, 208, 316, 236, 1, 0, 2, 0, 0, 7'h3f));
      else
        frame(mk("rally_right", 208, 208, 316 + 2 * m, y_down_first(m), 0, 0, 1, 0, 0, 7'h3f));
    end
    for (int p = 1; p <= 60; p++)
      frame(mk("point_r", 208, 208, 316, 236, 1, 0, (p == 60) ? 0 : 2, 0, 0, 7'h3f));

    // serve after a player-0 point goes right; move pad0 then reset mid-play
    io.serve_n = 1'b0;
    frame(mk("serve_r3", 208, 208, 316, 236, 1, 0, 1, 0, 0, 7'h3f));
    io.serve_n = 1'b1;
    frame(mk("serve_dir_r", 208, 208, 318, 238, 1, 0, 1, 0, 0, 7'h3f));
    io.up0_n = 1'b0;
    for (int m = 2; m <= 4; m++)
      frame(mk("play_pad", 208 - 4 * (m - 1), 208, 316 + 2 * m, 236 + 2 * m, 1, 0, 1, 0, 0, 7'h3f));
    io.up0_n = 1'b1;

    @(negedge clk);
    reset = 1'b1;
    sb.push_back(mk("reset_mid", 208, 208, 316, 236, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    frame(mk("after_reset", 208, 208, 316, 236, 0, 0, 0, 0, 0));

    repeat (10) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard", "leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
